// File: rtl/seq_detect_1011.sv
// seq_detect_1011: serial pattern detector for 1,0,1,1 (first bit first), overlap allowed.
// Moore FSM with a sample history shift register and a saturating detection counter.
//
// Ports
//   clk    in   rising-edge clock for all state
//   rst_n  in   synchronous active-low reset
//   a      in   serial data bit, sampled when en=1
//   en     in   sample enable; when 0 the FSM and history hold
//   clr    in   synchronous clear of count/sat, independent of en
//   det    out  high while the FSM sits in S4 (registered)
//   state  out  current FSM state encoding
//   hist   out  last four sampled bits, newest in bit 0
//   count  out  saturating detection count
//   sat    out  high while count == 255 (registered)
//
// state | meaning
// S0    | idle, no progress
// S1    | seen "1"
// S2    | seen "10"
// S3    | seen "101"
// S4    | seen "1011" (detect)
module seq_detect_1011 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       a,
   input  logic       en,
   input  logic       clr,
   output logic       det,
   output logic [2:0] state,
   output logic [3:0] hist,
   output logic [7:0] count,
   output logic       sat
);

   typedef enum logic [2:0] {
      S0 = 3'd0,
      S1 = 3'd1,
      S2 = 3'd2,
      S3 = 3'd3,
      S4 = 3'd4
   } state_t;

   // Held as a plain vector so the unused encodings 5-7 are representable
   // and can be recovered from.
   logic [2:0] state_q, state_d;
   logic       det_q, det_d;
   logic [3:0] hist_q, hist_d;
   logic [7:0] count_q, count_d;
   logic       sat_q, sat_d;
   logic       hit;

   always_comb begin
      state_d = state_q;
      hist_d  = hist_q;
      count_d = count_q;
      hit     = 1'b0;

      if (state_q > S4) begin
         state_d = S0;
      end else if (en) begin
         case (state_q)
            S0:      state_d = a ? S1 : S0;
            S1:      state_d = a ? S1 : S2;
            S2:      state_d = a ? S3 : S0;
            S3:      state_d = a ? S4 : S2;
            S4:      state_d = a ? S1 : S2;
            default: state_d = S0;
         endcase
         hit = a && (state_q == S3);
      end

      if (en) begin
         hist_d = {hist_q[2:0], a};
      end

      if (clr) begin
         count_d = 8'd0;
      end else if (hit && (count_q != 8'hFF)) begin
         count_d = count_q + 8'd1;
      end

      // det and sat are registered copies of conditions on the next state,
      // so they line up with state/count in the same cycle.
      det_d = (state_d == S4);
      sat_d = (count_d == 8'hFF);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S0;
         det_q   <= 1'b0;
         hist_q  <= 4'b0000;
         count_q <= 8'd0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         det_q   <= det_d;
         hist_q  <= hist_d;
         count_q <= count_d;
         sat_q   <= sat_d;
      end
   end

   assign state = state_q;
   assign det   = det_q;
   assign hist  = hist_q;
   assign count = count_q;
   assign sat   = sat_q;

endmodule
